op_scheduler: RTL and testbench

//  Round-robin scheduler sharing one operation unit among NUM_REQ user request channels.

---
 rtl/op_sched_pkg.sv | 17 +
 rtl/op_scheduler_rr_arbiter.sv | 33 +++
 rtl/op_scheduler.sv | 142 ++++++++++++++
 tb/tb_op_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_sched_pkg.sv
// Shared encodings for the op_scheduler slice: FSM state and operation-unit op codes.
package op_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SHL2 = 2'b01;
  localparam logic [1:0] OP_ROR2 = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/op_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr_i wins.
module rr_arbiter
  import op_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [7:0] req_pad;
  logic [3:0] cand;

  assign req_pad = 8'(req_i);

  // Walk from the farthest candidate back to ptr_i so the nearest one is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (req_pad[cand[2:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/op_scheduler.sv
// Round-robin scheduler sharing one operation unit among NUM_REQ channels.
// Optional ack watchdog enabled by `define OPSCHED_TIMEOUT_EN.
module op_scheduler
  import op_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_op_code,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic                 fifo_full,
  output logic                 op_start,
  output logic [1:0]           op_code,
  output logic [7:0]           data_in,
  input  logic                 ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_stray
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("op_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [NUM_REQ-1:0] DONE_CH0 = NUM_REQ'(1);

  state_e             state_q;
  logic               op_start_q, busy_q, err_to_q, err_stray_q;
  logic [1:0]         op_code_q;
  logic [7:0]         data_q;
  logic [NUM_REQ-1:0] done_q;
  logic [IDX_W-1:0]   grant_q, ptr_q, ptr_d;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [1:0]         sel_op;
  logic [7:0]         sel_data;

`ifdef OPSCHED_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        sel_op   = req_op_code[2*i +: 2];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  assign ptr_d = (win_idx == 3'(NUM_REQ - 1)) ? '0 : win_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_start_q  <= 1'b0;
      op_code_q   <= '0;
      data_q      <= '0;
      done_q      <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_stray_q <= 1'b0;
`ifdef OPSCHED_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      done_q   <= '0;
      err_to_q <= 1'b0;
      if (ack && state_q != ST_ISSUE) err_stray_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (win_valid && !fifo_full) begin
            op_code_q  <= sel_op;
            data_q     <= sel_data;
            grant_q    <= win_idx;
            ptr_q      <= ptr_d;
            op_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
`ifdef OPSCHED_TIMEOUT_EN
            wd_q       <= WD_LOAD;
`endif
          end
        end
        ST_ISSUE: begin
          if (ack) begin
            op_start_q <= 1'b0;
            done_q     <= DONE_CH0 << grant_q;
            state_q    <= ST_RELEASE;
          end
`ifdef OPSCHED_TIMEOUT_EN
          // Expiry aborts without a done pulse; the pointer already moved past this channel.
          else if (wd_q == '0) begin
            op_start_q <= 1'b0;
            err_to_q   <= 1'b1;
            state_q    <= ST_RELEASE;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          op_start_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_start    = op_start_q;
  assign op_code     = op_code_q;
  assign data_in     = data_q;
  assign done        = done_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign err_timeout = err_to_q;
  assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_op_scheduler.sv
// Scoreboard bench for op_scheduler with a behavioural operation unit and result FIFO.
module tb_op_scheduler;
  import op_sched_pkg::*;

  localparam int N = 4;
`ifdef OPSCHED_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] req_op_code = '0;
  logic [8*N-1:0] req_data = '0;
  logic           fifo_full = 1'b0, ack = 1'b0;
  logic           op_start, busy, err_timeout, err_stray;
  logic [1:0]     op_code;
  logic [7:0]     data_in;
  logic [N-1:0]   done;
  logic [2:0]     grant_id;

  op_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op_code(req_op_code), .req_data(req_data),
    .fifo_full(fifo_full), .op_start(op_start), .op_code(op_code), .data_in(data_in),
    .ack(ack), .done(done), .grant_id(grant_id), .busy(busy),
    .err_timeout(err_timeout), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [1:0] opc;
    logic [7:0] din;
    logic [7:0] res;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int n_vec = 0, n_miss = 0, done_cnt = 0, to_cnt = 0;
  bit unit_stall = 0, stray_req = 0, unit_fired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Operation unit: acks one cycle after it sees op_start, once per op_start level.
  logic       s_start;
  logic [1:0] s_op;
  logic [7:0] s_d, s_res;
  always begin
    @(posedge clk);
    s_start = op_start; s_op = op_code; s_d = data_in;
    #1;
    if (stray_req) begin
      ack = 1'b1; stray_req = 0;
    end else if (s_start === 1'b1 && !unit_fired && !unit_stall) begin
      case (s_op)
        OP_PASS: s_res = s_d;
        OP_SHL2: s_res = s_d << 2;
        OP_ROR2: s_res = {s_d[1:0], s_d[7:2]};
        default: s_res = ~s_d;
      endcase
      fifo_q.push_back(s_res);
      ack = 1'b1; unit_fired = 1;
    end else begin
      ack = 1'b0;
      if (s_start !== 1'b1) unit_fired = 0;
    end
  end

  exp_t       m_e;
  logic [7:0] m_last;
  always @(negedge clk) begin
    if (err_timeout === 1'b1) to_cnt++;
    if (done !== '0) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_done: got done=%b expected none", done);
      end else begin
        m_e = exp_q.pop_front();
        m_last = (fifo_q.size() > 0) ? fifo_q[$] : 8'hxx;
        chk("done_onehot", 32'(done), 32'(1) << m_e.ch);
        chk("grant_id", 32'(grant_id), 32'(m_e.ch));
        chk("op_code", 32'(op_code), 32'(m_e.opc));
        chk("data_in", 32'(data_in), 32'(m_e.din));
        chk("fifo_result", 32'(m_last), 32'(m_e.res));
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] opc, input logic [7:0] d);
    req_op_code[2*ch +: 2] = opc;
    req_data[8*ch +: 8]    = d;
  endtask

  task automatic push_exp(input int ch, input logic [1:0] opc, input logic [7:0] d, input logic [7:0] r);
    exp_t e;
    e.ch = ch; e.opc = opc; e.din = d; e.res = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_dones(input int target, input int bound, input string name);
    int k = 0;
    while (done_cnt < target && k < bound) begin tick(); k++; end
    n_vec++;
    if (done_cnt < target) begin
      n_miss++;
      $display("FAIL %s: got %0d done pulses expected %0d within %0d cycles", name, done_cnt, target, bound);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    int hi;
    bit seen;
    tick(); tick();
    chk("rst_op_start", 32'(op_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_err", 32'({err_timeout, err_stray}), 0);
    rst = 1'b0;

    // 1: single request timing
    tick();
    set_ch(0, OP_SHL2, 8'h3C); req = 4'b0001;
    push_exp(0, OP_SHL2, 8'h3C, 8'hF0);
    chk("t1_c0_op_start", 32'(op_start), 0);
    tick();
    chk("t1_c1_op_start", 32'(op_start), 1);
    chk("t1_c1_busy", 32'(busy), 1);
    chk("t1_c1_op_code", 32'(op_code), 32'(OP_SHL2));
    chk("t1_c1_data", 32'(data_in), 32'h3C);
    tick();
    chk("t1_c2_op_start", 32'(op_start), 1);
    chk("t1_c2_done", 32'(done), 0);
    tick();
    chk("t1_c3_op_start", 32'(op_start), 0);
    chk("t1_c3_done", 32'(done), 32'b0001);
    chk("t1_c3_busy", 32'(busy), 1);
    tick();
    req = '0;
    chk("t1_c4_done", 32'(done), 0);
    chk("t1_c4_busy", 32'(busy), 0);
    tick(); tick();

    // 2: all channels held, rotation 0,1,2,3,0
    do_reset();
    set_ch(0, OP_PASS, 8'h11); set_ch(1, OP_SHL2, 8'h22);
    set_ch(2, OP_ROR2, 8'h33); set_ch(3, OP_INV, 8'h44);
    push_exp(0, OP_PASS, 8'h11, 8'h11); push_exp(1, OP_SHL2, 8'h22, 8'h88);
    push_exp(2, OP_ROR2, 8'h33, 8'hCC); push_exp(3, OP_INV, 8'h44, 8'hBB);
    push_exp(0, OP_PASS, 8'h11, 8'h11);
    req = 4'b1111;
    wait_dones(done_cnt + 5, 40, "t2_rotation");
    req = '0;
    tick(); tick();

    // 3: fifo_full holds off issue
    set_ch(2, OP_ROR2, 8'hA5); fifo_full = 1'b1; req = 4'b0100;
    repeat (6) tick();
    chk("t3_blocked_op_start", 32'(op_start), 0);
    chk("t3_blocked_busy", 32'(busy), 0);
    fifo_full = 1'b0;
    push_exp(2, OP_ROR2, 8'hA5, 8'h69);
    tick();
    chk("t3_issue_op_start", 32'(op_start), 1);
    chk("t3_issue_grant", 32'(grant_id), 2);
    wait_dones(done_cnt + 1, 10, "t3_done");
    req = '0;
    tick(); tick();

    // 4: reset in the ack cycle aborts; pointer returns to channel 0
    set_ch(1, OP_INV, 8'h0F); req = 4'b0010;
    tick();
    chk("t4_c1_grant", 32'(grant_id), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("t4_op_start", 32'(op_start), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_outs", 32'({grant_id, op_code, data_in}), 0);
    chk("t4_err", 32'({err_timeout, err_stray}), 0);
    rst = 1'b0; req = '0;
    tick(); tick();
    set_ch(0, OP_PASS, 8'h5A); set_ch(2, OP_SHL2, 8'h81);
    push_exp(0, OP_PASS, 8'h5A, 8'h5A); push_exp(2, OP_SHL2, 8'h81, 8'h04);
    req = 4'b0101;
    wait_dones(done_cnt + 2, 20, "t4_after_reset");
    req = '0;
    tick(); tick();

    // 5: stray ack in IDLE
    chk("t5_stray_before", 32'(err_stray), 0);
    stray_req = 1;
    tick(); tick();
    chk("t5_stray_set", 32'(err_stray), 1);
    chk("t5_idle", 32'({busy, op_start}), 0);
    repeat (5) tick();
    chk("t5_stray_sticky", 32'(err_stray), 1);

    // 6: unit never acks
    unit_stall = 1;
`ifdef OPSCHED_TIMEOUT_EN
    set_ch(3, OP_PASS, 8'h77); set_ch(0, OP_INV, 8'hF0);
    req = 4'b1001;
    hi = 0; seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      if (err_timeout === 1'b1) seen = 1;
      else if (op_start === 1'b1) hi++;
    end
    chk("t6_timeout_seen", 32'(seen), 1);
    chk("t6_issue_cycles", 32'(hi), 8);
    chk("t6_op_start_low", 32'(op_start), 0);
    chk("t6_no_done", 32'(done), 0);
    req = 4'b0001;
    push_exp(0, OP_INV, 8'hF0, 8'h0F);
    tick();
    unit_stall = 0;
    wait_dones(done_cnt + 1, 10, "t6_next_channel");
    req = '0;
    tick(); tick();
    chk("t6_timeout_pulses", 32'(to_cnt), 1);
`else
    set_ch(3, OP_PASS, 8'h77);
    req = 4'b1000;
    hi = 0;
    tick();
    for (int k = 0; k < 80; k++) begin
      tick();
      if (op_start === 1'b1) hi++;
    end
    chk("t6_waits_forever", 32'(hi), 80);
    chk("t6_no_timeout", 32'(to_cnt), 0);
    push_exp(3, OP_PASS, 8'h77, 8'h77);
    unit_stall = 0;
    wait_dones(done_cnt + 1, 10, "t6_late_ack");
    req = '0;
    tick(); tick();
`endif

    chk("end_scoreboard_empty", 32'(exp_q.size()), 0);
    chk("end_stray_sticky", 32'(err_stray), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
